// File: rtl/dmcache_pkg.sv
// Shared definitions for the direct-mapped cache tag store: flush FSM
// encodings and the index-width to entry-count derivation.
package dmcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flushState_t;

    // Number of entries addressed by an index of the given width.
    function automatic int depthOf(input int indexW);
        return 1 << indexW;
    endfunction

endpackage

// File: rtl/dmcache_flush_seq.sv
// Flush sequencer: walks a pointer over every entry, one per cycle,
// requesting a valid-bit clear, then pulses flushDone for one cycle.
// Writes and invalidates are held off (wrReady=0) while the walk runs.
module dmcache_flush_seq
    import dmcache_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               flushReq,
    output logic               flushBusy,
    output logic               flushDone,
    output logic               wrReady,
    output logic               clearEn,
    output logic [INDEX_W-1:0] clearIdx
);

    localparam int                 DEPTH   = depthOf(INDEX_W);
    localparam logic [INDEX_W-1:0] LAST_IX = INDEX_W'(DEPTH - 1);

    flushState_t        stateReg;
    flushState_t        stateNext;
    logic [INDEX_W-1:0] ptrReg;
    logic [INDEX_W-1:0] ptrNext;

    // State and pointer registers; reset aborts any flush in progress.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stateReg <= IDLE;
            ptrReg   <= '0;
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
        end
    end

    // Next-state, pointer advance and status outputs.
    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        flushBusy = 1'b0;
        flushDone = 1'b0;
        wrReady   = 1'b1;
        clearEn   = 1'b0;
        case (stateReg)
            IDLE: begin
                if (flushReq) begin
                    stateNext = FLUSH;
                    ptrNext   = '0;
                end
            end
            FLUSH: begin
                flushBusy = 1'b1;
                wrReady   = 1'b0;
                clearEn   = 1'b1;
                // The last entry is cleared this cycle; the pointer holds
                // rather than wrapping back to zero.
                if (ptrReg == LAST_IX) begin
                    stateNext = DONE;
                end else begin
                    ptrNext = ptrReg + 1'b1;
                end
            end
            DONE: begin
                flushDone = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign clearIdx = ptrReg;

endmodule

// File: rtl/cache_tag_array.sv
// Direct-mapped cache tag store: per-entry tag and valid bit, a single
// write/invalidate port, NUM_RD combinational read/compare ports with
// optional same-cycle write forwarding, and a sequenced full flush.
module cache_tag_array
    import dmcache_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 13,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      wrEn,
    input  logic [INDEX_W-1:0]        wrIdx,
    input  logic [TAG_W-1:0]          wrTag,
    input  logic                      invEn,
    input  logic [INDEX_W-1:0]        invIdx,
    input  logic                      flushReq,
    input  logic [NUM_RD*INDEX_W-1:0] rdIdx,
    input  logic [NUM_RD*TAG_W-1:0]   cmpTag,
    output logic [NUM_RD*TAG_W-1:0]   rdTag,
    output logic [NUM_RD-1:0]         rdValid,
    output logic [NUM_RD-1:0]         hit,
    output logic                      wrReady,
    output logic                      flushBusy,
    output logic                      flushDone
);

    localparam int DEPTH = depthOf(INDEX_W);

    logic [DEPTH-1:0]   validReg;
    logic [TAG_W-1:0]   tagMem [DEPTH];
    logic               clearEn;
    logic [INDEX_W-1:0] clearIdx;
    logic               wrAcc;
    logic               invAcc;

    dmcache_flush_seq #(
        .INDEX_W (INDEX_W)
    ) flushSeq (
        .clk       (clk),
        .clr       (clr),
        .flushReq  (flushReq),
        .flushBusy (flushBusy),
        .flushDone (flushDone),
        .wrReady   (wrReady),
        .clearEn   (clearEn),
        .clearIdx  (clearIdx)
    );

    // Requests are accepted only when the sequencer is not flushing; the
    // clr term keeps forwarding off while reset is held so read ports
    // show reset values.
    assign wrAcc  = wrEn  & wrReady & clr;
    assign invAcc = invEn & wrReady & clr;

    // Entry state. Later assignments take priority, so a write to the same
    // index as an invalidate leaves the entry valid with the new tag.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            validReg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tagMem[i] <= '0;
            end
        end else begin
            if (clearEn) begin
                validReg[clearIdx] <= 1'b0;
            end
            if (invAcc) begin
                validReg[invIdx] <= 1'b0;
            end
            if (wrAcc) begin
                validReg[wrIdx] <= 1'b1;
                tagMem[wrIdx]   <= wrTag;
            end
        end
    end

    // One combinational read/compare path per port.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRead
            logic [INDEX_W-1:0] portIdx;
            logic [TAG_W-1:0]   portTag;
            logic               portValid;
            logic               fwd;

            assign portIdx = rdIdx[gi*INDEX_W +: INDEX_W];
            assign fwd     = (BYPASS != 0) && wrAcc && (portIdx == wrIdx);

            // Forward the in-flight write when enabled, else stored state.
            always_comb begin
                portTag   = tagMem[portIdx];
                portValid = validReg[portIdx];
                if (fwd) begin
                    portTag   = wrTag;
                    portValid = 1'b1;
                end
            end

            assign rdTag[gi*TAG_W +: TAG_W] = portTag;
            assign rdValid[gi]              = portValid;
            assign hit[gi]                  = portValid && (portTag == cmpTag[gi*TAG_W +: TAG_W]);
        end
    endgenerate

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array: one BYPASS=1 instance for all
// features plus a BYPASS=0 instance sharing the same stimulus.
module tb_cache_tag_array;

    localparam int INDEX_W = 4;
    localparam int TAG_W   = 13;
    localparam int NUM_RD  = 2;
    localparam int DEPTH   = 16;

    logic                      clk = 1'b0;
    logic                      clr;
    logic                      wrEn;
    logic [INDEX_W-1:0]        wrIdx;
    logic [TAG_W-1:0]          wrTag;
    logic                      invEn;
    logic [INDEX_W-1:0]        invIdx;
    logic                      flushReq;
    logic [NUM_RD*INDEX_W-1:0] rdIdx;
    logic [NUM_RD*TAG_W-1:0]   cmpTag;

    logic [NUM_RD*TAG_W-1:0]   rdTag,   rdTag0;
    logic [NUM_RD-1:0]         rdValid, rdValid0;
    logic [NUM_RD-1:0]         hit,     hit0;
    logic                      wrReady, wrReady0;
    logic                      flushBusy, flushBusy0;
    logic                      flushDone, flushDone0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .NUM_RD(NUM_RD), .BYPASS(1)) dut (
        .clk(clk), .clr(clr), .wrEn(wrEn), .wrIdx(wrIdx), .wrTag(wrTag),
        .invEn(invEn), .invIdx(invIdx), .flushReq(flushReq),
        .rdIdx(rdIdx), .cmpTag(cmpTag), .rdTag(rdTag), .rdValid(rdValid),
        .hit(hit), .wrReady(wrReady), .flushBusy(flushBusy), .flushDone(flushDone)
    );

    cache_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .NUM_RD(NUM_RD), .BYPASS(0)) dut0 (
        .clk(clk), .clr(clr), .wrEn(wrEn), .wrIdx(wrIdx), .wrTag(wrTag),
        .invEn(invEn), .invIdx(invIdx), .flushReq(flushReq),
        .rdIdx(rdIdx), .cmpTag(cmpTag), .rdTag(rdTag0), .rdValid(rdValid0),
        .hit(hit0), .wrReady(wrReady0), .flushBusy(flushBusy0), .flushDone(flushDone0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input logic [3:0] i0, input logic [3:0] i1,
                           input logic [12:0] c0, input logic [12:0] c1);
        rdIdx  = {i1, i0};
        cmpTag = {c1, c0};
    endtask

    task automatic fillAll();
        for (int i = 0; i < DEPTH; i++) begin
            wrEn  = 1'b1;
            wrIdx = 4'(i);
            wrTag = 13'(32'h20 + i);
            tick();
        end
        wrEn = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; wrEn = 1'b0; wrIdx = '0; wrTag = '0; invEn = 1'b0; invIdx = '0;
        flushReq = 1'b0;
        setRead(4'd0, 4'd9, 13'h0, 13'h0);
        tick();
        tick();
        checks++;
        if (rdValid !== 2'b00 || hit !== 2'b00 || rdTag !== '0) begin
            errors++;
            $display("FAIL reset_read: rdValid=%b hit=%b rdTag=%h expected 00 00 0", rdValid, hit, rdTag);
        end
        checks++;
        if (flushBusy !== 1'b0 || flushDone !== 1'b0 || wrReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b wrReady=%b expected 0 0 1", flushBusy, flushDone, wrReady);
        end
        clr = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_write_hit();
        wrEn = 1'b1; wrIdx = 4'd3; wrTag = 13'h1A5;
        tick();
        wrEn = 1'b0;
        setRead(4'd3, 4'd3, 13'h1A5, 13'h1A4);
        #1;
        checks++;
        if (hit !== 2'b01 || rdValid !== 2'b11) begin
            errors++;
            $display("FAIL write_hit: hit=%b rdValid=%b expected 01 11", hit, rdValid);
        end
        checks++;
        if (rdTag[12:0] !== 13'h1A5) begin
            errors++;
            $display("FAIL write_tag: rdTag0=%h expected 1a5", rdTag[12:0]);
        end
        $display("write_hit: idx3 hit=%b tag=%h", hit, rdTag[12:0]);
    endtask

    task automatic test_bypass();
        wrEn = 1'b1; wrIdx = 4'd5; wrTag = 13'h0F0;
        setRead(4'd3, 4'd5, 13'h1A5, 13'h0F0);
        #1;
        checks++;
        if (hit[1] !== 1'b1 || rdTag[25:13] !== 13'h0F0) begin
            errors++;
            $display("FAIL bypass_on: hit1=%b tag1=%h expected 1 0f0", hit[1], rdTag[25:13]);
        end
        checks++;
        if (hit0[1] !== 1'b0 || rdValid0[1] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_off: hit1=%b valid1=%b expected 0 0", hit0[1], rdValid0[1]);
        end
        tick();
        wrEn = 1'b0;
        #1;
        checks++;
        if (hit0[1] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_off_after: hit1=%b expected 1", hit0[1]);
        end
        $display("bypass: fwd hit=%b nofwd-after hit=%b", hit[1], hit0[1]);
    endtask

    task automatic test_wr_inv();
        wrEn = 1'b1; wrIdx = 4'd7; wrTag = 13'h055; invEn = 1'b1; invIdx = 4'd7;
        tick();
        wrEn = 1'b1; wrIdx = 4'd8; wrTag = 13'h100; invEn = 1'b0;
        tick();
        wrEn = 1'b0;
        setRead(4'd7, 4'd8, 13'h055, 13'h100);
        #1;
        checks++;
        if (rdValid !== 2'b11 || rdTag[12:0] !== 13'h055) begin
            errors++;
            $display("FAIL wr_inv_same: rdValid=%b tag0=%h expected 11 055", rdValid, rdTag[12:0]);
        end
        wrEn = 1'b1; wrIdx = 4'd7; wrTag = 13'h077; invEn = 1'b1; invIdx = 4'd8;
        tick();
        wrEn = 1'b0; invEn = 1'b0;
        setRead(4'd7, 4'd8, 13'h077, 13'h100);
        #1;
        checks++;
        if (rdValid !== 2'b01 || hit !== 2'b01 || rdTag[25:13] !== 13'h100) begin
            errors++;
            $display("FAIL wr_inv_diff: rdValid=%b hit=%b tag1=%h expected 01 01 100", rdValid, hit, rdTag[25:13]);
        end
        $display("wr_inv: idx7/idx8 rdValid=%b", rdValid);
    endtask

    task automatic test_flush();
        int busyCount = 0;
        int doneCyc   = -1;
        fillAll();
        setRead(4'd0, 4'd15, 13'h20, 13'h2F);
        #1;
        checks++;
        if (hit !== 2'b11) begin
            errors++;
            $display("FAIL fill: hit=%b expected 11", hit);
        end
        flushReq = 1'b1;
        tick();
        flushReq = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            wrEn = (cyc == 3); wrIdx = 4'd2; wrTag = 13'h1FFF;
            if (cyc == 3) begin
                checks++;
                if (wrReady !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_wrready: wrReady=%b expected 0", wrReady);
                end
            end
            if (cyc == 6) begin
                setRead(4'd2, 4'd10, 13'h22, 13'h2A);
                #1;
                checks++;
                if (rdValid !== 2'b10 || hit !== 2'b10) begin
                    errors++;
                    $display("FAIL flush_midread: rdValid=%b hit=%b expected 10 10", rdValid, hit);
                end
            end
            if (flushBusy === 1'b1) busyCount++;
            if (flushDone === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            tick();
        end
        wrEn = 1'b0;
        checks++;
        if (doneCyc != 17 || busyCount != 16) begin
            errors++;
            $display("FAIL flush_timing: doneCyc=%0d busy=%0d expected 17 16", doneCyc, busyCount);
        end
        tick();
        checks++;
        if (flushDone !== 1'b0 || flushBusy !== 1'b0 || wrReady !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: done=%b busy=%b wrReady=%b expected 0 0 1", flushDone, flushBusy, wrReady);
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            setRead(4'(i), 4'(i + 1), 13'(32'h20 + i), 13'(32'h21 + i));
            #1;
            checks++;
            if (rdValid !== 2'b00 || hit !== 2'b00) begin
                errors++;
                $display("FAIL flush_cleared: idx=%0d rdValid=%b hit=%b expected 00 00", i, rdValid, hit);
            end
        end
        $display("flush: busy=%0d cycles done on cycle %0d", busyCount, doneCyc);
    endtask

    task automatic test_reset_mid_flush();
        int sawDone  = 0;
        int doneCyc  = -1;
        fillAll();
        flushReq = 1'b1;
        tick();
        flushReq = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) tick();
        clr = 1'b0;
        setRead(4'd12, 4'd13, 13'h0, 13'h0);
        #1;
        checks++;
        if (flushBusy !== 1'b0 || flushDone !== 1'b0 || wrReady !== 1'b1 ||
            rdValid !== 2'b00 || hit !== 2'b00 || rdTag !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b wrReady=%b rdValid=%b hit=%b rdTag=%h expected 0 0 1 00 00 0",
                     flushBusy, flushDone, wrReady, rdValid, hit, rdTag);
        end
        tick();
        clr = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (flushDone === 1'b1) sawDone++;
            tick();
        end
        checks++;
        if (sawDone != 0) begin
            errors++;
            $display("FAIL abort_no_done: flushDone pulses=%0d expected 0", sawDone);
        end
        wrEn = 1'b1; wrIdx = 4'd0; wrTag = 13'h111;
        tick();
        wrIdx = 4'd15; wrTag = 13'h0FF;
        tick();
        wrEn = 1'b0;
        flushReq = 1'b1;
        tick();
        flushReq = 1'b0;
        tick();
        setRead(4'd0, 4'd15, 13'h111, 13'h0FF);
        #1;
        checks++;
        if (rdValid !== 2'b10) begin
            errors++;
            $display("FAIL restart_ptr: rdValid=%b expected 10", rdValid);
        end
        for (int cyc = 2; cyc <= 40; cyc++) begin
            if (flushDone === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (doneCyc != 17) begin
            errors++;
            $display("FAIL restart_timing: doneCyc=%0d expected 17", doneCyc);
        end
        $display("reset_mid_flush: restart done on cycle %0d", doneCyc);
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_bypass();
        test_wr_inv();
        test_flush();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_tag_array.md
CACHE_TAG_ARRAY -- requirements
Module: cache_tag_array

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, meaning entry index width (DEPTH = 2**INDEX_W).
REQ-002 The block SHALL have parameter TAG_W, default 13, meaning stored tag width.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of independent read/compare ports (1..4).
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write forwarding to reads, 0 = none.
REQ-005 The block SHALL have port clk, input, 1, meaning single clock; all state changes on rising edge.
REQ-006 The block SHALL have port clr, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port wrEn, input, 1, meaning tag write request.
REQ-008 The block SHALL have port wrIdx, input, INDEX_W, meaning write index.
REQ-009 The block SHALL have port wrTag, input, TAG_W, meaning tag to store.
REQ-010 The block SHALL have port invEn, input, 1, meaning single-entry invalidate request.
REQ-011 The block SHALL have port invIdx, input, INDEX_W, meaning invalidate index.
REQ-012 The block SHALL have port flushReq, input, 1, meaning start invalidation of all entries.
REQ-013 The block SHALL have port rdIdx, input, NUM_RD*INDEX_W, meaning packed read indices (port k at bits k*INDEX_W upward).
REQ-014 The block SHALL have port cmpTag, input, NUM_RD*TAG_W, meaning packed compare tags.
REQ-015 The block SHALL have port rdTag, output, NUM_RD*TAG_W, meaning packed stored tags.
REQ-016 The block SHALL have port rdValid, output, NUM_RD, meaning per-port valid bit of addressed entry.
REQ-017 The block SHALL have port hit, output, NUM_RD, meaning per-port rdValid AND (rdTag == cmpTag).
REQ-018 The block SHALL have port wrReady, output, 1, meaning writes/invalidates accepted this cycle.
REQ-019 The block SHALL have port flushBusy, output, 1, meaning flush in progress.
REQ-020 The block SHALL have port flushDone, output, 1, meaning one-cycle pulse at flush completion.

Function
REQ-021 Reads SHALL be combinational: rdTag, rdValid, hit reflect stored state for rdIdx in the same cycle, zero latency.
REQ-022 wrEn=1 with wrReady=1 SHALL store wrTag at wrIdx and set its valid bit at the next rising edge.
REQ-023 invEn=1 with wrReady=1 SHALL clear the valid bit at invIdx (tag unchanged) at the next rising edge.
REQ-024 wrEn and invEn on the same index in one cycle: write SHALL win (entry valid, new tag); on different indices both SHALL take effect.
REQ-025 With BYPASS=1, wrEn=1, wrReady=1 and rdIdx[k]==wrIdx, port k SHALL output rdTag=wrTag, rdValid=1 and compute hit from them; with BYPASS=0, port k SHALL show pre-write contents.
REQ-026 Flush FSM states SHALL be IDLE, FLUSH, DONE; IDLE->FLUSH on flushReq=1 with pointer=0.
REQ-027 In FLUSH, each cycle SHALL clear valid[pointer] and increment pointer; at pointer==DEPTH-1 (clearing it) SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with flushDone=1, then go to IDLE; flushReq to flushDone latency SHALL be DEPTH+1 cycles.
REQ-029 flushBusy SHALL be 1 exactly in FLUSH; wrReady SHALL be 0 in FLUSH, 1 in IDLE and DONE.
REQ-030 wrEn/invEn while wrReady=0 SHALL be dropped silently; flushReq outside IDLE SHALL be ignored.
REQ-031 During FLUSH, reads SHALL reflect current state (already-cleared entries read rdValid=0, hit=0).
REQ-032 The pointer SHALL be INDEX_W bits wide and SHALL not wrap beyond DEPTH-1 within one flush.

Reset
REQ-033 clr=0 SHALL asynchronously clear all valid bits and tags to 0, FSM to IDLE, pointer to 0.
REQ-034 During and after reset: rdValid=0, hit=0, rdTag=0, flushBusy=0, flushDone=0, wrReady=1.
REQ-035 Reset asserted mid-flush SHALL abort the flush without a flushDone pulse.

Structure
REQ-036 FSM state encodings and the DEPTH derivation SHALL live in shared package dmcache_pkg.
REQ-037 The flush FSM and pointer SHALL be sub-module dmcache_flush_seq; storage and read ports stay in cache_tag_array.

Verification
REQ-038 Reset, write idx 3 tag 0x1A5, read port 0 idx 3 cmpTag 0x1A5 -> hit[0]=1, rdTag=0x1A5; port 1 cmpTag 0x1A4 -> hit[1]=0.
REQ-039 BYPASS=1: wrEn idx 5 tag 0x0F0 with rdIdx[1]=5, cmpTag 0x0F0 same cycle -> hit[1]=1 before edge; BYPASS=0 -> hit[1]=0.
REQ-040 Fill all 16 entries, flushReq one cycle -> flushBusy high 16 cycles, flushDone pulse on cycle 17, all rdValid=0; wrEn idx 2 during FLUSH dropped.
REQ-041 Same cycle wrEn idx 7 tag 0x055 and invEn idx 7 -> entry 7 valid, tag 0x055; invEn idx 8 with wrEn idx 7 -> 8 invalid, 7 valid.
REQ-042 clr low at flush cycle 6 -> immediate all outputs at reset values, no flushDone, flushReq after release restarts at pointer 0.
